// File: rtl/scope_renderer.sv
// scope_renderer: captures one triggered ADC sweep into a ping-pong buffer and renders trace/graticule pixels
module scope_renderer #(
    parameter int SAMPLE_W     = 8,
    parameter int NSAMP        = 640,
    parameter int AUTO_TIMEOUT = 65535
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic [SAMPLE_W-1:0] trig_level,
    input  logic                trig_rising,
    input  logic                auto_trig,
    input  logic [9:0]          x,
    input  logic [9:0]          y,
    output logic                r,
    output logic                g,
    output logic                b,
    output logic                triggered,
    output logic                frame_swap
);
    localparam int IW = $clog2(NSAMP);
    localparam int CW = $clog2(AUTO_TIMEOUT + 1);

    typedef enum logic [1:0] {WAIT_TRIG, CAPTURE, DONE} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       wr_idx_q, wr_idx_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                prev_ok_q, prev_ok_d;
    logic [SAMPLE_W-1:0] prev_q, prev_d;
    logic                front_q, front_d;
    logic                disp_valid_q, disp_valid_d;
    logic                we;
    logic [IW-1:0]       wa;
    logic                edge_hit;
    logic                timeout;

    logic [SAMPLE_W-1:0] mem0 [NSAMP];
    logic [SAMPLE_W-1:0] mem1 [NSAMP];

    logic [IW-1:0]       ra;
    logic [SAMPLE_W-1:0] rd_q, rd_d, rd_prev_q;
    logic [9:0]          x1_q, y1_q;
    logic [9:0]          row_a, row_b, lo, hi;
    logic                vis, grid, trace;
    logic                r_q, r_d, g_q, g_d, b_q, b_d;

    always_comb begin
        state_d      = state_q;
        wr_idx_d     = wr_idx_q;
        cnt_d        = cnt_q;
        prev_ok_d    = prev_ok_q;
        prev_d       = prev_q;
        front_d      = front_q;
        disp_valid_d = disp_valid_q;
        we           = 1'b0;
        wa           = wr_idx_q;
        triggered    = 1'b0;
        frame_swap   = 1'b0;
        edge_hit     = prev_ok_q && (trig_rising ? (prev_q < trig_level && sample >= trig_level)
                                                 : (prev_q > trig_level && sample <= trig_level));
        timeout      = cnt_q == CW'(AUTO_TIMEOUT - 1);
        if (rst_n) begin
            case (state_q)
                WAIT_TRIG: if (sample_valid) begin
                    if (edge_hit || (auto_trig && timeout)) begin
                        triggered = 1'b1;
                        we        = 1'b1;
                        wa        = '0;
                        wr_idx_d  = IW'(1);
                        state_d   = CAPTURE;
                    end else begin
                        prev_d    = sample;
                        prev_ok_d = 1'b1;
                        cnt_d     = timeout ? cnt_q : cnt_q + 1'b1;
                    end
                end
                CAPTURE: if (sample_valid) begin
                    we       = 1'b1;
                    wr_idx_d = wr_idx_q + 1'b1;
                    state_d  = (wr_idx_q == IW'(NSAMP - 1)) ? DONE : CAPTURE;
                end
                DONE: if (x == 10'd0 && y == 10'd480) begin
                    frame_swap   = 1'b1;
                    front_d      = ~front_q;
                    disp_valid_d = 1'b1;
                    cnt_d        = '0;
                    prev_ok_d    = 1'b0;
                    state_d      = WAIT_TRIG;
                end
                default: state_d = WAIT_TRIG;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= WAIT_TRIG;
            wr_idx_q     <= '0;
            cnt_q        <= '0;
            prev_ok_q    <= 1'b0;
            disp_valid_q <= 1'b0;
            front_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_idx_q     <= wr_idx_d;
            cnt_q        <= cnt_d;
            prev_ok_q    <= prev_ok_d;
            disp_valid_q <= disp_valid_d;
            front_q      <= front_d;
        end
        prev_q <= prev_d;
    end

    // the back buffer is whichever bank is not being displayed
    always_ff @(posedge clk) begin
        if (we) begin
            if (front_q) mem0[wa] <= sample;
            else         mem1[wa] <= sample;
        end
    end

    always_comb begin
        ra    = (x < 10'(NSAMP)) ? x[IW-1:0] : '0;
        rd_d  = front_q ? mem1[ra] : mem0[ra];
        row_a = 10'd367 - 10'(rd_q);
        row_b = (x1_q == 10'd0) ? row_a : 10'd367 - 10'(rd_prev_q);
        lo    = (row_a < row_b) ? row_a : row_b;
        hi    = (row_a < row_b) ? row_b : row_a;
        vis   = x1_q < 10'd640 && y1_q < 10'd480;
        grid  = x1_q[5:0] == 6'd0 || y1_q % 10'd60 == 10'd0 || x1_q == 10'd639 || y1_q == 10'd479;
        trace = disp_valid_q && x1_q < 10'(NSAMP) && y1_q >= lo && y1_q <= hi;
        r_d   = vis && trace;
        g_d   = vis && trace;
        b_d   = vis && !trace && grid;
    end

    always_ff @(posedge clk) begin
        x1_q      <= x;
        y1_q      <= y;
        rd_q      <= rd_d;
        rd_prev_q <= rd_q;
        if (!rst_n) begin
            r_q <= 1'b0;
            g_q <= 1'b0;
            b_q <= 1'b0;
        end else begin
            r_q <= r_d;
            g_q <= g_d;
            b_q <= b_d;
        end
    end

    assign r = r_q;
    assign g = g_q;
    assign b = b_q;
endmodule

// File: tb/tb_scope_renderer.sv
// tb_scope_renderer: randomized scoreboard bench for scope_renderer against a sweep-level reference model
module tb_scope_renderer;
    localparam int NS = 640;
    localparam int AT = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sample_valid = 1'b0;
    logic [7:0] sample = '0;
    logic [7:0] trig_level = 8'd128;
    logic       trig_rising = 1'b1;
    logic       auto_trig = 1'b0;
    logic [9:0] x = '0;
    logic [9:0] y = '0;
    logic       r, g, b, triggered, frame_swap;

    scope_renderer #(.SAMPLE_W(8), .NSAMP(NS), .AUTO_TIMEOUT(AT)) dut (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample(sample),
        .trig_level(trig_level), .trig_rising(trig_rising), .auto_trig(auto_trig),
        .x(x), .y(y), .r(r), .g(g), .b(b), .triggered(triggered), .frame_swap(frame_swap)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int         due;
        logic [2:0] exp;
        int         px;
        int         py;
    } pix_t;
    pix_t pixq[$];
    int   trigq[$];
    int   swapq[$];
    int   feed[$];
    int   src = 0;

    // reference model: sweep-level view of arming, captured samples and displayed frame
    bit armed = 1'b1;
    bit have_prev = 1'b0;
    int prev = 0;
    int cnt = 0;
    int cap[$];
    int fr[NS];
    bit dv = 1'b0;

    int t1_rows[16] = '{0, 1, 59, 60, 61, 100, 120, 239, 240, 300, 367, 420, 479, 480, 500, 524};

    function automatic bit m_done();
        return !armed && cap.size() == NS;
    endfunction

    function automatic logic [2:0] pix_model(int px, int py);
        int a, c, lo, hi;
        if (px >= 640 || py >= 480) return 3'b000;
        a  = 367 - fr[px];
        c  = (px == 0) ? a : 367 - fr[px-1];
        lo = (a < c) ? a : c;
        hi = (a < c) ? c : a;
        if (dv && py >= lo && py <= hi) return 3'b110;
        if (px % 64 == 0 || py % 60 == 0 || px == 639 || py == 479) return 3'b001;
        return 3'b000;
    endfunction

    task automatic cyc_step(input bit rn, input bit v, input int s, input int px, input int py);
        int lvl;
        bit hit;
        rst_n        = rn;
        sample_valid = v;
        sample       = 8'(s);
        x            = 10'(px);
        y            = 10'(py);
        lvl          = int'(trig_level);
        if (!rn) begin
            armed = 1; have_prev = 0; cnt = 0; dv = 0;
            cap.delete();
            if (pixq.size() > 0 && pixq[$].due == cyc + 1) pixq[$].exp = 3'b000;
        end else if (armed) begin
            if (v) begin
                cnt++;
                hit = have_prev && (trig_rising ? (prev < lvl && s >= lvl) : (prev > lvl && s <= lvl));
                if (hit || (auto_trig && cnt >= AT)) begin
                    armed = 0;
                    cap = {s};
                    trigq.push_back(cyc);
                end else begin
                    prev = s;
                    have_prev = 1;
                end
            end
        end else if (cap.size() < NS) begin
            if (v) cap.push_back(s);
        end else if (px == 0 && py == 480) begin
            for (int i = 0; i < NS; i++) fr[i] = cap[i];
            dv = 1; armed = 1; have_prev = 0; cnt = 0;
            swapq.push_back(cyc);
        end
        pixq.push_back('{due: cyc + 2, exp: pix_model(px, py), px: px, py: py});
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input int px, input int py);
        bit v;
        int s;
        v = 1'b0;
        s = int'($urandom_range(0, 255));
        if (feed.size() > 0) begin
            v = 1'b1;
            s = feed.pop_front();
        end else if (src == 1) begin
            v = $urandom_range(0, 1) == 1;
        end
        cyc_step(1'b1, v, s, px, py);
    endtask

    task automatic scan_row(input int py, input int rst_at);
        for (int px = 0; px < 646; px++) begin
            if (px == rst_at) cyc_step(1'b0, 1'b1, 7, px, py);
            else tick(px, py);
        end
    endtask

    task automatic drain();
        while (feed.size() > 0) tick(700, 490);
        tick(700, 490);
    endtask

    task automatic vblank();
        tick(1, 480);
        tick(0, 479);
        tick(0, 480);
        tick(1, 480);
    endtask

    always @(negedge clk) begin
        bit et, es;
        pix_t p;
        while (pixq.size() > 0 && pixq[0].due < cyc) void'(pixq.pop_front());
        if (pixq.size() > 0 && pixq[0].due == cyc) begin
            p = pixq.pop_front();
            checks++;
            if ({r, g, b} !== p.exp) begin
                failures++;
                $display("FAIL pixel x=%0d y=%0d got rgb=%b want rgb=%b", p.px, p.py, {r, g, b}, p.exp);
            end
        end
        et = trigq.size() > 0 && trigq[0] == cyc;
        if (et) void'(trigq.pop_front());
        if (triggered || et) begin
            checks++;
            if (triggered !== et) begin
                failures++;
                $display("FAIL triggered cyc=%0d got %b want %b", cyc, triggered, et);
            end
        end
        es = swapq.size() > 0 && swapq[0] == cyc;
        if (es) void'(swapq.pop_front());
        if (frame_swap || es) begin
            checks++;
            if (frame_swap !== es) begin
                failures++;
                $display("FAIL frame_swap cyc=%0d got %b want %b", cyc, frame_swap, es);
            end
        end
    end

    initial begin
        int sw[NS];
        int n;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) cyc_step(1'b0, 1'b0, 0, 64, 60);

        // blank frame: graticule only
        foreach (t1_rows[i]) scan_row(t1_rows[i], -1);

        // rising ramp triggers on 128
        for (int i = 0; i < 780; i++) feed.push_back(i % 256);
        scan_row(30, -1);
        drain();
        vblank();
        scan_row(112, -1); scan_row(113, -1); scan_row(240, -1);
        scan_row(366, -1); scan_row(367, -1); scan_row(368, -1);
        for (int i = 0; i < 3; i++) scan_row(int'($urandom_range(112, 367)), -1);

        // auto trigger on a flat signal
        cyc_step(1'b0, 1'b0, 0, 700, 490);
        cyc_step(1'b0, 1'b0, 0, 700, 490);
        auto_trig = 1'b1;
        for (int i = 0; i < 700; i++) feed.push_back(100);
        scan_row(267, -1);
        drain();
        vblank();
        scan_row(266, -1); scan_row(267, -1); scan_row(268, -1);

        // full-height segment at column 10
        auto_trig = 1'b0;
        for (int i = 0; i < NS; i++) sw[i] = int'($urandom_range(0, 255));
        sw[0] = 200; sw[8] = 0; sw[9] = 0; sw[10] = 255;
        feed.push_back(50);
        for (int i = 0; i < NS; i++) feed.push_back(sw[i]);
        drain();
        vblank();
        scan_row(112, -1); scan_row(200, -1); scan_row(366, -1); scan_row(367, -1);
        for (int i = 0; i < 2; i++) scan_row(int'($urandom_range(112, 367)), -1);

        // random capture completing mid-frame; swap-cycle sample must not arm the trigger
        src = 1;
        trig_rising = $urandom_range(0, 1) == 1;
        trig_level = 8'($urandom_range(50, 200));
        n = 0;
        while (!m_done() && n < 20) begin
            scan_row(int'($urandom_range(0, 479)), -1);
            n++;
        end
        src = 0;
        trig_rising = 1'b1;
        trig_level = 8'd128;
        feed.push_back(0); feed.push_back(255); feed.push_back(255);
        tick(0, 479);
        tick(0, 480);
        tick(0, 480);
        tick(0, 480);
        for (int i = 0; i < 3; i++) scan_row(int'($urandom_range(100, 400)), -1);

        // reset mid-capture, then a fresh sweep
        src = 1;
        trig_level = 8'($urandom_range(50, 200));
        n = 0;
        while (!(!armed && cap.size() > 100) && n < 20) begin
            scan_row(60, -1);
            n++;
        end
        scan_row(60, 200);
        scan_row(240, -1);
        scan_row(int'($urandom_range(112, 367)), -1);
        n = 0;
        while (!m_done() && n < 20) begin
            scan_row(int'($urandom_range(0, 479)), -1);
            n++;
        end
        src = 0;
        vblank();
        for (int i = 0; i < 3; i++) scan_row(int'($urandom_range(112, 367)), -1);

        for (int i = 0; i < 4; i++) tick(700, 490);
        checks++;
        if (trigq.size() != 0 || swapq.size() != 0 || pixq.size() > 2) begin
            failures++;
            $display("FAIL pending got trig=%0d swap=%0d pix=%0d want 0", trigq.size(), swapq.size(), pixq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
